fifo_window_priority_encoder: RTL and testbench
===============================================

Name: fifo_window_priority_encoder

Overview:
Circular-window priority encoder for FIFO/ROB-style structures with 2^ADDR_WIDTH slots. It searches a request vector only inside the occupied window [head, tail) and reports the set bit nearest to either the head or the tail pointer, chosen by parameter. The search is combinational and the result is registered, so it fits in issue/commit select logic of the out-of-order core.

Parameters:
ADDR_WIDTH, 3, pointer width; SLOTS = 2^ADDR_WIDTH (derived localparam, not overridable)
CLOSEST_TO, "tail", search direction: "head" selects the first set bit after head; "tail" selects the first set bit before tail; any other value is a compile-time error

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
inputs  input  SLOTS  request vector; bit k = slot k
head  input  ADDR_WIDTH  window start slot (inclusive)
tail  input  ADDR_WIDTH  window end slot (exclusive)
valid  output  1  registered; a set bit was found in the window
index  output  ADDR_WIDTH  registered; slot index of the selected bit

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Window: slots head, head+1, ..., tail-1, modulo SLOTS. Window length L = (tail - head) mod SLOTS. L=0 (head==tail) means a full window: all SLOTS slots are searched.
- CLOSEST_TO="head": candidates are examined in the order head, head+1, ... The first set bit within L steps is selected.
- CLOSEST_TO="tail": candidates are examined in the order tail-1, tail-2, ... The first set bit within L steps is selected.
- All index arithmetic is ADDR_WIDTH-bit with natural wrap-around. There is no saturation.
- Combinational core: rotate inputs right by head, so window bit 0 = slot head. Mask bits at positions >= L, unless L=0. Priority-encode the lowest set bit for head mode, or the highest set bit for tail mode. Add head back, modulo SLOTS.
- Outputs are registered with 1-cycle latency. At each rising clock edge, valid/index take the result computed from the inputs/head/tail values present just before that edge.
- No set bit in the window: valid=0 and index=0. Index is forced to 0, not held.
- Reset: while reset_n=0, valid=0 and index=0 immediately, regardless of the clock. Asserting reset mid-operation discards the pending result. The first result after deassertion is captured at the first rising edge with reset_n=1.
- No handshake; the block samples every cycle.
- Bits of inputs outside the window never influence the outputs.

Decomposition:
- The shared package holds no typedefs.
- Constants are local: SLOTS, and an encoded direction flag derived from CLOSEST_TO.
- One natural sub-module, priority_encoder_lsb (parameter WIDTH): finds the lowest set bit of a WIDTH-bit vector and outputs valid plus index.
- Tail mode reuses priority_encoder_lsb on the bit-reversed masked vector; the index is then converted back as L-1-i (or SLOTS-1-i when L=0).

Test Plan:
- Use inputs=8'b10101011 throughout (slots 0,1,3,5,7 set). Each response appears one clock after the stimulus.
- CLOSEST_TO="tail", head=0, tail=3 -> valid=1, index=1. Same stimulus with CLOSEST_TO="head" -> valid=1, index=0.
- Wrap-around, tail mode, head=4, tail=3 (window 4..7,0..2) -> index=1. Head mode, head=6, tail=1 (window 6,7,0) -> index=7 (slot 6 is clear).
- Full window (head==tail=3): tail mode -> index=1; head mode -> index=3. Empty match: head=2, tail=3 (window {2}, slot 2 clear) -> valid=0, index=0.
- Pointer sweep: head increments every cycle and tail every 8 cycles, for 64 cycles. Every registered result must match a software model of the ordered search, including head==tail cycles.
- Reset: drive a matching stimulus, then pull reset_n low between clock edges -> valid=0 and index=0 immediately. Release reset_n -> the correct result appears after the first rising edge.

Source files
------------

// File: rtl/fifo_window_priority_encoder_pkg.sv
// Shared helpers for the circular-window priority encoder: decodes the
// search-direction selector and checks that it is legal.
package fifo_window_priority_encoder_pkg;

   localparam logic [31:0] DIR_HEAD_STR = "head";
   localparam logic [31:0] DIR_TAIL_STR = "tail";

   // The selector arrives as a 4-character string packed into 32 bits.
   function automatic logic dir_is_tail(input logic [31:0] sel);
      return sel == DIR_TAIL_STR;
   endfunction

   function automatic logic dir_is_legal(input logic [31:0] sel);
      return (sel == DIR_HEAD_STR) || (sel == DIR_TAIL_STR);
   endfunction

endpackage

// File: rtl/fifo_window_priority_encoder_lsb.sv
// Lowest-set-bit priority encoder: reports whether any bit is set and the
// position of the lowest one.
module priority_encoder_lsb
   import fifo_window_priority_encoder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]         vec,
   output logic                     found,
   output logic [$clog2(WIDTH)-1:0] index
);

   localparam int IW = $clog2(WIDTH);

   // Scan from the top down so the last hit is the lowest set bit.
   always_comb begin
      found = 1'b0;
      index = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (vec[i]) begin
            found = 1'b1;
            index = IW'(i);
         end
      end
   end

endmodule

// File: rtl/fifo_window_priority_encoder.sv
// Circular-window priority encoder. Searches inputs only inside [head, tail)
// (head == tail means every slot), picks the set bit nearest head or tail,
// and registers the result with one cycle of latency.
module fifo_window_priority_encoder
   import fifo_window_priority_encoder_pkg::*;
#(
   parameter int ADDR_WIDTH = 3,
   parameter     CLOSEST_TO = "tail"
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic [(1<<ADDR_WIDTH)-1:0]   inputs,
   input  logic [ADDR_WIDTH-1:0]        head,
   input  logic [ADDR_WIDTH-1:0]        tail,
   output logic                         valid,
   output logic [ADDR_WIDTH-1:0]        index
);

   localparam int                    SLOTS   = 1 << ADDR_WIDTH;
   localparam logic                  IS_TAIL = dir_is_tail(CLOSEST_TO);
   localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);

   if (!dir_is_legal(CLOSEST_TO)) begin : g_bad_direction
      $error("CLOSEST_TO must be \"head\" or \"tail\"");
   end

   logic [ADDR_WIDTH-1:0] len;
   logic [SLOTS-1:0]      window;
   logic [SLOTS-1:0]      masked;
   logic [SLOTS-1:0]      reversed;
   logic [SLOTS-1:0]      enc_vec;
   logic                  enc_found;
   logic [ADDR_WIDTH-1:0] enc_index;
   logic [ADDR_WIDTH-1:0] offset;
   logic [ADDR_WIDTH-1:0] result_index;

   // Rotate so window position 0 is slot head, then drop positions >= len.
   always_comb begin
      len    = tail - head;
      window = '0;
      masked = '0;
      for (int k = 0; k < SLOTS; k++) begin
         window[k] = (len == '0) || (ADDR_WIDTH'(k) < len);
         masked[k] = window[k] & inputs[head + ADDR_WIDTH'(k)];
      end
   end

   // Reverse only the live window (all slots when len wraps to 0) so the
   // bit nearest tail becomes the lowest bit for the shared encoder.
   always_comb begin
      reversed = '0;
      for (int k = 0; k < SLOTS; k++) begin
         reversed[k] = window[k] & masked[len - ONE - ADDR_WIDTH'(k)];
      end
   end

   assign enc_vec = IS_TAIL ? reversed : masked;

   priority_encoder_lsb #(
      .WIDTH (SLOTS)
   ) u_lsb (
      .vec   (enc_vec),
      .found (enc_found),
      .index (enc_index)
   );

   // len - 1 - i also yields SLOTS - 1 - i when len is 0, thanks to wrap.
   always_comb begin
      offset       = IS_TAIL ? (len - ONE - enc_index) : enc_index;
      result_index = head + offset;
   end

   // Register the search result; a miss forces index to 0.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid <= 1'b0;
         index <= '0;
      end else begin
         valid <= enc_found;
         index <= enc_found ? result_index : '0;
      end
   end

endmodule

// File: tb/tb_fifo_window_priority_encoder.sv
// Scoreboard bench: stimulus pushes expected {valid,index} per instance,
// a monitor pops and compares one cycle later.
module tb_fifo_window_priority_encoder;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [7:0] inputs;
   logic [2:0] head;
   logic [2:0] tail;
   logic       valid_t, valid_h;
   logic [2:0] index_t, index_h;

   int n_tests = 0;
   int n_fail  = 0;

   logic [3:0] q_tail[$];
   logic [3:0] q_head[$];

   always #5 clock = ~clock;

   fifo_window_priority_encoder #(.ADDR_WIDTH(3), .CLOSEST_TO("tail")) dut_tail (
      .clock   (clock),
      .reset_n (reset_n),
      .inputs  (inputs),
      .head    (head),
      .tail    (tail),
      .valid   (valid_t),
      .index   (index_t)
   );

   fifo_window_priority_encoder #(.ADDR_WIDTH(3), .CLOSEST_TO("head")) dut_head (
      .clock   (clock),
      .reset_n (reset_n),
      .inputs  (inputs),
      .head    (head),
      .tail    (tail),
      .valid   (valid_h),
      .index   (index_h)
   );

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got valid=%0b index=%0d, expected valid=%0b index=%0d",
                  name, act[3], act[2:0], exp[3], exp[2:0]);
      end
   endtask

   // Ordered search over the window, one slot at a time.
   function automatic logic [3:0] model(input logic is_tail, input logic [7:0] vec,
                                        input logic [2:0] h, input logic [2:0] t);
      logic [2:0] l;
      logic [2:0] slot;
      int         n;
      l = t - h;
      n = (l == 3'd0) ? 8 : int'(l);
      for (int s = 0; s < n; s++) begin
         slot = is_tail ? (t - 3'd1 - 3'(s)) : (h + 3'(s));
         if (vec[slot]) return {1'b1, slot};
      end
      return 4'b0000;
   endfunction

   task automatic apply(input logic [2:0] h, input logic [2:0] t,
                        input logic [3:0] exp_t, input logic [3:0] exp_h);
      @(negedge clock);
      head = h;
      tail = t;
      q_tail.push_back(exp_t);
      q_head.push_back(exp_h);
   endtask

   // Monitor: the DUT presents a result every cycle, compare when one is owed.
   initial begin
      logic [3:0] e;
      forever begin
         @(posedge clock);
         #1;
         if (q_tail.size() > 0) begin
            e = q_tail.pop_front();
            check("tail_mode", {valid_t, index_t}, e);
         end
         if (q_head.size() > 0) begin
            e = q_head.pop_front();
            check("head_mode", {valid_h, index_h}, e);
         end
      end
   end

   typedef struct {
      logic [2:0] h;
      logic [2:0] t;
      logic [3:0] exp_t;
      logic [3:0] exp_h;
   } vec_t;

   vec_t dir_vecs[7] = '{
      '{3'd0, 3'd3, 4'b1001, 4'b1000},   // window 0..2
      '{3'd4, 3'd3, 4'b1001, 4'b1101},   // wrap 4..7,0..2
      '{3'd6, 3'd1, 4'b1000, 4'b1111},   // wrap 6,7,0
      '{3'd3, 3'd3, 4'b1001, 4'b1011},   // full window from 3
      '{3'd2, 3'd3, 4'b0000, 4'b0000},   // window {2}, clear
      '{3'd7, 3'd7, 4'b1101, 4'b1111},   // full window from 7
      '{3'd1, 3'd2, 4'b1001, 4'b1001}    // window {1}, set
   };

   initial begin
      reset_n = 1'b0;
      inputs  = 8'b10101011;
      head    = 3'd0;
      tail    = 3'd3;
      #12;
      check("reset_tail", {valid_t, index_t}, 4'b0000);
      check("reset_head", {valid_h, index_h}, 4'b0000);
      @(negedge clock);
      reset_n = 1'b1;

      foreach (dir_vecs[i])
         apply(dir_vecs[i].h, dir_vecs[i].t, dir_vecs[i].exp_t, dir_vecs[i].exp_h);

      for (int c = 0; c < 64; c++) begin
         logic [2:0] h;
         logic [2:0] t;
         h = 3'(c);
         t = 3'(c >> 3);
         apply(h, t, model(1'b1, inputs, h, t), model(1'b0, inputs, h, t));
      end

      // Reset between edges while a match is present.
      apply(3'd0, 3'd3, 4'b1001, 4'b1000);
      @(negedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_reset_tail", {valid_t, index_t}, 4'b0000);
      check("async_reset_head", {valid_h, index_h}, 4'b0000);
      @(negedge clock);
      check("held_reset_tail", {valid_t, index_t}, 4'b0000);
      reset_n = 1'b1;
      q_tail.push_back(4'b1001);
      q_head.push_back(4'b1000);

      @(negedge clock);
      @(negedge clock);
      check("drain_tail", {1'b0, 3'(q_tail.size())}, 4'b0000);
      check("drain_head", {1'b0, 3'(q_head.size())}, 4'b0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
